// File: rtl/hsi_msg_tx_ctrl.sv
// HSI master message transmitter: arbitrates pending request types and frames
// marker, flag, payload and checksum bytes onto the byte coder's busy handshake.
module hsi_msg_tx_ctrl #(
  parameter int unsigned          N_TYPES = 3,
  parameter int unsigned          MSG_LEN = 5,
  parameter logic [7:0]           MARKER  = 8'hA5,
  parameter logic [N_TYPES*8-1:0] FLAGS   = 24'h040201
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_TYPES-1:0] req,
  input  logic               abort,
  input  logic [7:0]         pl_data,
  input  logic               cd_busy,
  output logic [7:0]         q,
  output logic               q_rdy,
  output logic               msg_end,
  output logic [N_TYPES-1:0] active,
  output logic [7:0]         pl_idx,
  output logic               tx_busy
);

  localparam int unsigned BW      = 8;
  localparam logic [BW-1:0] LAST    = BW'(MSG_LEN - 1);
  localparam logic [BW-1:0] PL_LAST = BW'(MSG_LEN - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_TYPES-1:0]  pending_q, pending_d;
  logic [N_TYPES-1:0]  active_q, active_d;
  logic [BW-1:0]       cntr_q, cntr_d;
  logic [BW-1:0]       chk_q, chk_d;
  logic [BW-1:0]       byte_q, byte_d;
  logic [BW-1:0]       pl_idx_q, pl_idx_d;
  logic                msg_end_q, msg_end_d;

  logic                pick_found;
  logic [N_TYPES-1:0]  pick_oh;
  logic [N_TYPES-1:0]  clr_c;
  logic [BW-1:0]       flag_c;
  logic [BW-1:0]       nxt_c;
  logic                is_pl_c;
  logic                nxt_pl_c;
  logic [BW-1:0]       q_c;

  // Lowest pending index wins
  always_comb begin
    pick_found = 1'b0;
    pick_oh    = '0;
    for (int unsigned i = 0; i < N_TYPES; i++) begin
      if (pending_q[i] && !pick_found) begin
        pick_found = 1'b1;
        pick_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    flag_c = '0;
    for (int unsigned i = 0; i < N_TYPES; i++) begin
      if (active_q[i]) flag_c = FLAGS[8*i +: 8];
    end
  end

  assign is_pl_c  = (cntr_q >= BW'(2)) && (cntr_q <= PL_LAST);
  assign nxt_c    = cntr_q + BW'(1);
  assign nxt_pl_c = (nxt_c >= BW'(2)) && (nxt_c <= PL_LAST);

  // Payload bytes come straight from the user until acceptance latches them
  assign q_c = ((state_q == ST_SEND) && is_pl_c) ? pl_data : byte_q;

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    cntr_d    = cntr_q;
    chk_d     = chk_q;
    byte_d    = byte_q;
    pl_idx_d  = pl_idx_q;
    msg_end_d = 1'b0;
    clr_c     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          clr_c    = pick_oh;
          active_d = pick_oh;
          cntr_d   = '0;
          chk_d    = '0;
          byte_d   = MARKER;
          pl_idx_d = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cd_busy) begin
          state_d = ST_WAIT;
          byte_d  = q_c;
          if ((cntr_q >= BW'(1)) && (cntr_q <= PL_LAST)) chk_d = chk_q + q_c;
        end
      end
      ST_WAIT: begin
        if (!cd_busy) begin
          if (cntr_q == LAST) begin
            state_d   = ST_IDLE;
            msg_end_d = 1'b1;
            active_d  = '0;
            byte_d    = '0;
            pl_idx_d  = '0;
          end else begin
            state_d  = ST_SEND;
            cntr_d   = nxt_c;
            pl_idx_d = nxt_pl_c ? (nxt_c - BW'(2)) : '0;
            if (nxt_c == BW'(1))  byte_d = flag_c;
            else if (nxt_c == LAST) byte_d = chk_q;
            else                  byte_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort drops the message but leaves queued requests intact
    if (abort) begin
      state_d   = ST_IDLE;
      active_d  = '0;
      byte_d    = '0;
      pl_idx_d  = '0;
      msg_end_d = 1'b0;
      clr_c     = '0;
    end

    pending_d = (pending_q & ~clr_c) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      active_q  <= '0;
      cntr_q    <= '0;
      chk_q     <= '0;
      byte_q    <= '0;
      pl_idx_q  <= '0;
      msg_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      cntr_q    <= cntr_d;
      chk_q     <= chk_d;
      byte_q    <= byte_d;
      pl_idx_q  <= pl_idx_d;
      msg_end_q <= msg_end_d;
    end
  end

  assign q       = q_c;
  assign q_rdy   = (state_q == ST_SEND) && !cd_busy;
  assign msg_end = msg_end_q;
  assign active  = active_q;
  assign pl_idx  = pl_idx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hsi_msg_tx_ctrl.sv
// Bench for hsi_msg_tx_ctrl: random coder/payload stimulus against a
// message-level model (marker, flag, payload, modulo-256 sum).
module tb_hsi_msg_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, abort, cd_busy, q_rdy, msg_end, tx_busy;
  logic [2:0] req, active;
  logic [7:0] pl_data, q, pl_idx;

  logic       req3, abort3, cd_busy3, q_rdy3, msg_end3, tx_busy3;
  logic [0:0] req3_v, active3;
  logic [7:0] pl_data3, q3, pl_idx3;

  hsi_msg_tx_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .pl_data(pl_data),
    .cd_busy(cd_busy), .q(q), .q_rdy(q_rdy), .msg_end(msg_end),
    .active(active), .pl_idx(pl_idx), .tx_busy(tx_busy)
  );

  assign req3_v = req3;
  hsi_msg_tx_ctrl #(.N_TYPES(1), .MSG_LEN(3), .MARKER(8'hA5), .FLAGS(8'h7F)) dut3 (
    .clk(clk), .rst(rst), .req(req3_v), .abort(abort3), .pl_data(pl_data3),
    .cd_busy(cd_busy3), .q(q3), .q_rdy(q_rdy3), .msg_end(msg_end3),
    .active(active3), .pl_idx(pl_idx3), .tx_busy(tx_busy3)
  );

  int errors = 0;
  int checks = 0;
  int end_cnt = 0;
  int coder_len = 0;
  int busy_left = 0;

  logic [7:0] pl_tab [3][2];
  logic [7:0] rec_q[$], exp_q[$];
  logic [2:0] rec_a[$], exp_a[$];

  // User side: payload byte looked up by the type and index the DUT shows
  always_comb begin
    pl_data = 8'h00;
    for (int t = 0; t < 3; t++)
      if (active[t] && pl_idx < 8'd2) pl_data = pl_tab[t][pl_idx[0]];
  end

  // Coder model: accepts a ready byte, stays busy for a random/fixed span
  initial begin
    cd_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (abort || rst) begin
        cd_busy = 1'b0;
        busy_left = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) cd_busy = 1'b0;
      end else if (q_rdy) begin
        rec_q.push_back(q);
        rec_a.push_back(active);
        cd_busy = 1'b1;
        busy_left = (coder_len != 0) ? coder_len : int'($urandom_range(1, 5));
      end
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (msg_end) end_cnt++;
  end

  task automatic clear_all();
    rec_q.delete(); rec_a.delete(); exp_q.delete(); exp_a.delete();
    end_cnt = 0;
  endtask

  task automatic rand_pl();
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < 2; k++) pl_tab[t][k] = 8'($urandom);
  endtask

  task automatic push_exp(input int t);
    logic [7:0] f, s;
    f = 8'(1 << t);
    s = f;
    exp_q.push_back(8'hA5);
    exp_q.push_back(f);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pl_tab[t][k]);
      s = s + pl_tab[t][k];
    end
    exp_q.push_back(s);
    repeat (5) exp_a.push_back(3'(1 << t));
  endtask

  function automatic int first_diff();
    if (rec_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < rec_q.size(); i++)
      if (rec_q[i] !== exp_q[i] || rec_a[i] !== exp_a[i]) return i;
    return -1;
  endfunction

  task automatic pulse(input logic [2:0] v);
    @(negedge clk) req = v;
    @(negedge clk) req = 3'b000;
  endtask

  task automatic wait_ends(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (end_cnt >= n && !tx_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_recs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rec_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; req = 3'b000;
    abort3 = 1'b0; req3 = 1'b0; cd_busy3 = 1'b0; pl_data3 = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (q !== 8'h00)       begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (q_rdy !== 1'b0)    begin errors++; $display("FAIL reset_q_rdy got=%b exp=0", q_rdy); end
    checks++; if (msg_end !== 1'b0)  begin errors++; $display("FAIL reset_msg_end got=%b exp=0", msg_end); end
    checks++; if (active !== 3'b000) begin errors++; $display("FAIL reset_active got=%b exp=000", active); end
    checks++; if (pl_idx !== 8'h00)  begin errors++; $display("FAIL reset_pl_idx got=%h exp=00", pl_idx); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int d;
    pl_tab[0][0] = 8'h10; pl_tab[0][1] = 8'h20;
    coder_len = 4;
    clear_all();
    exp_q = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h31};
    repeat (5) exp_a.push_back(3'b001);
    @(negedge clk) req = 3'b001;
    @(negedge clk) req = 3'b000;
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_pending_cycle tx_busy got=%b exp=0", tx_busy); end
    @(negedge clk);
    checks++; if ({tx_busy, active} !== 4'b1001) begin errors++; $display("FAIL single_send_entry got=%b exp=1001", {tx_busy, active}); end
    wait_ends(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout ends=%0d exp=1", end_cnt); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL single_bytes at=%0d got_n=%0d exp_n=%0d", d, rec_q.size(), exp_q.size()); end
    repeat (5) @(negedge clk);
    checks++; if (end_cnt != 1) begin errors++; $display("FAIL single_msg_end_count got=%0d exp=1", end_cnt); end
  endtask

  task automatic test_priority();
    bit ok;
    int d;
    rand_pl(); coder_len = 0; clear_all();
    push_exp(1); push_exp(2);
    pulse(3'b110);
    wait_ends(2, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout ends=%0d exp=2", end_cnt); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL prio_bytes at=%0d got_n=%0d exp_n=%0d", d, rec_q.size(), exp_q.size()); end
    repeat (20) @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || end_cnt != 2) begin errors++; $display("FAIL prio_pending_empty tx_busy=%b ends=%0d exp=0/2", tx_busy, end_cnt); end
  endtask

  task automatic test_requeue();
    bit ok, seen;
    int d;
    rand_pl(); coder_len = 0; clear_all();
    push_exp(0); push_exp(0);
    pulse(3'b001);
    wait_recs(3, 200, ok);
    pulse(3'b001);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (msg_end) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || tx_busy !== 1'b0) begin errors++; $display("FAIL requeue_first_end seen=%b tx_busy=%b exp=1/0", seen, tx_busy); end
    @(negedge clk);
    checks++; if ({tx_busy, active} !== 4'b1001) begin errors++; $display("FAIL requeue_restart got=%b exp=1001", {tx_busy, active}); end
    wait_ends(2, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL requeue_timeout ends=%0d exp=2", end_cnt); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL requeue_bytes at=%0d got_n=%0d exp_n=%0d", d, rec_q.size(), exp_q.size()); end
  endtask

  task automatic test_abort();
    bit ok;
    int d;
    rand_pl(); coder_len = 4; clear_all();
    pulse(3'b100);
    wait_recs(1, 100, ok);
    pulse(3'b010);
    wait_recs(3, 200, ok);
    @(negedge clk);
    checks++; if ({cd_busy, tx_busy, q_rdy} !== 3'b110) begin errors++; $display("FAIL abort_in_wait got=%b exp=110", {cd_busy, tx_busy, q_rdy}); end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++; if ({tx_busy, q_rdy, msg_end, active} !== 6'b0) begin errors++; $display("FAIL abort_idle got=%b exp=000000", {tx_busy, q_rdy, msg_end, active}); end
    checks++; if (end_cnt != 0) begin errors++; $display("FAIL abort_no_end got=%0d exp=0", end_cnt); end
    clear_all();
    push_exp(1);
    wait_ends(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout ends=%0d exp=1", end_cnt); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL abort_restart_bytes at=%0d got_n=%0d exp_n=%0d", d, rec_q.size(), exp_q.size()); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int d;
    rand_pl(); coder_len = 0; clear_all();
    pulse(3'b111);
    wait_recs(4, 200, ok);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++; if ({q, q_rdy, msg_end, active, pl_idx, tx_busy} !== 22'b0) begin errors++; $display("FAIL rst_mid_outputs got=%h exp=0", {q, q_rdy, msg_end, active, pl_idx, tx_busy}); end
    rst = 1'b0;
    clear_all();
    repeat (40) @(negedge clk);
    checks++; if (tx_busy !== 1'b0 || rec_q.size() != 0 || end_cnt != 0) begin errors++; $display("FAIL rst_mid_quiet tx_busy=%b recs=%0d ends=%0d exp=0/0/0", tx_busy, rec_q.size(), end_cnt); end
    push_exp(2);
    pulse(3'b100);
    wait_ends(1, 300, ok);
    d = first_diff();
    checks++; if (!ok || d != -1) begin errors++; $display("FAIL rst_mid_next_msg ok=%b at=%0d got_n=%0d exp_n=%0d", ok, d, rec_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int d, n;
    logic [2:0] v;
    for (int r = 0; r < 8; r++) begin
      rand_pl(); coder_len = 0; clear_all();
      v = 3'($urandom_range(1, 7));
      n = 0;
      for (int t = 0; t < 3; t++) if (v[t]) begin push_exp(t); n++; end
      pulse(v);
      wait_ends(n, 800, ok);
      d = first_diff();
      checks++; if (!ok || d != -1) begin errors++; $display("FAIL random_round%0d req=%b ok=%b at=%0d got_n=%0d exp_n=%0d", r, v, ok, d, rec_q.size(), exp_q.size()); end
      repeat (3) @(negedge clk);
      checks++; if (end_cnt != n) begin errors++; $display("FAIL random_ends%0d got=%0d exp=%0d", r, end_cnt, n); end
    end
  endtask

  task automatic test_short();
    logic [7:0] r3[$];
    int left, e3;
    bit bad;
    left = 0; e3 = 0; bad = 1'b0;
    @(negedge clk) req3 = 1'b1;
    @(negedge clk) req3 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (msg_end3) e3++;
      if (tx_busy3 && pl_idx3 != 8'h00) bad = 1'b1;
      if (left > 0) begin
        left--;
        if (left == 0) cd_busy3 = 1'b0;
      end else if (q_rdy3) begin
        r3.push_back(q3);
        cd_busy3 = 1'b1;
        left = 2;
      end
    end
    checks++; if (r3.size() != 3) begin errors++; $display("FAIL short_len got=%0d exp=3", r3.size()); end
    else begin
      checks++; if ({r3[0], r3[1], r3[2]} !== 24'hA57F7F) begin errors++; $display("FAIL short_bytes got=%h exp=a57f7f", {r3[0], r3[1], r3[2]}); end
    end
    checks++; if (e3 != 1) begin errors++; $display("FAIL short_msg_end got=%0d exp=1", e3); end
    checks++; if (bad) begin errors++; $display("FAIL short_pl_idx got=nonzero exp=00"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_requeue();
    test_abort();
    test_rst_mid();
    test_random();
    test_short();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
